// File: rtl/coin_pkg.sv
// Shared coin denominations and dispenser state encoding.
// Also used by the vending machine, so codes and values must stay stable.
package coin_pkg;

    typedef logic [4:0] coin_t;

    localparam int unsigned NUM_DENOMS = 5;

    localparam coin_t NICKEL  = 5'b00001;
    localparam coin_t DIME    = 5'b00010;
    localparam coin_t QUARTER = 5'b00100;
    localparam coin_t HALFD   = 5'b01000;
    localparam coin_t FULLD   = 5'b10000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Cent value of a one-hot denomination; anything not one-hot is worth nothing.
    function automatic int unsigned coin_value(input coin_t c);
        int unsigned v;
        unique case (c)
            NICKEL:  v = 5;
            DIME:    v = 10;
            QUARTER: v = 25;
            HALFD:   v = 50;
            FULLD:   v = 100;
            default: v = 0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational pick of the largest non-empty denomination not exceeding the
// remaining amount.
module coin_select
    import coin_pkg::*;
#(
    parameter int unsigned AMT_W = 8
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [4:0]       empty,
    output coin_t            sel,
    output logic [AMT_W-1:0] value,
    output logic             none_eligible
);

    always_comb begin
        sel           = '0;
        value         = '0;
        none_eligible = 1'b1;
        // Ascending scan: the last eligible hit is the largest denomination.
        for (int unsigned i = 0; i < NUM_DENOMS; i++) begin
            if (!empty[i] && (32'(remaining) >= coin_value(coin_t'(1 << i)))) begin
                sel           = coin_t'(1 << i);
                value         = AMT_W'(coin_value(coin_t'(1 << i)));
                none_eligible = 1'b0;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: greedy coin selection, one coin presented to the
// hopper at a time with a valid/ack handshake.
module change_dispenser
    import coin_pkg::*;
#(
    parameter int unsigned AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic [4:0]       empty,
    input  logic             coin_ack,
    output logic [4:0]       coin,
    output logic             coin_valid,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] shortfall,
    output logic [3:0]       coin_count
);

    logic [1:0]       state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    coin_t            coin_q, coin_d;
    logic [AMT_W-1:0] value_q, value_d;
    logic             short_q, short_d;
    logic [AMT_W-1:0] shortfall_q, shortfall_d;
    logic [3:0]       count_q, count_d;

    coin_t            sel;
    logic [AMT_W-1:0] sel_value;
    logic             none_eligible;

    coin_select #(
        .AMT_W (AMT_W)
    ) u_coin_select (
        .remaining     (remaining_q),
        .empty         (empty),
        .sel           (sel),
        .value         (sel_value),
        .none_eligible (none_eligible)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin_d      = coin_q;
        value_d     = value_q;
        short_d     = short_q;
        shortfall_d = shortfall_q;
        count_d     = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = amount;
                    short_d     = 1'b0;
                    shortfall_d = '0;
                    count_d     = '0;
                    state_d     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (remaining_q == '0) begin
                    state_d = ST_DONE;
                end else if (none_eligible) begin
                    short_d     = 1'b1;
                    shortfall_d = remaining_q;
                    state_d     = ST_DONE;
                end else begin
                    // Latch the choice so later empty changes cannot disturb it.
                    coin_d  = sel;
                    value_d = sel_value;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (coin_ack) begin
                    remaining_d = remaining_q - value_q;
                    count_d     = (count_q == 4'd15) ? 4'd15 : count_q + 4'd1;
                    state_d     = ST_SELECT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            coin_q      <= '0;
            value_q     <= '0;
            short_q     <= 1'b0;
            shortfall_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_q      <= coin_d;
            value_q     <= value_d;
            short_q     <= short_d;
            shortfall_q <= shortfall_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        coin_valid = (state_q == ST_ISSUE);
        coin       = coin_valid ? coin_q : 5'b00000;
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        short      = short_q;
        shortfall  = shortfall_q;
        coin_count = count_q;
    end

endmodule
